axi_rd_arbiter: RTL
===================

// Module: axi_rd_arbiter
// PURPOSE
//  Round-robin arbiter for the shared AXI read channel (AR/R) among 4 masters.
//  Grants one master per read burst: grant is held from AR handshake through the R beat carrying RLAST.
//  Grant is then handed to the next requester. Sits beside the write-channel arbiter; its one-hot grant drives the AR/R muxes.
//  A watchdog releases a burst that stalls.
// PARAMETERS
//  NUM_M     4    number of masters (fixed at 4 in this revision; width of request/grant vectors)
//  TO_CYC    1024 watchdog limit in cycles per burst; 0 disables watchdog
//  TO_W      11   watchdog counter width; must satisfy 2**TO_W > TO_CYC
//  TCO       1    simulation clock-to-out delay on every sequential assignment
// PORTS
//  ACLK       in   1      clock, rising edge
//  ARESETn    in   1      reset, asynchronous, active-low
//  m_arvalid  in   4      ARVALID per master, bit i = master i
//  m_rready   in   4      RREADY per master
//  s_arready  in   1      ARREADY from the shared slave side
//  s_rvalid   in   1      RVALID from the shared slave side
//  s_rlast    in   1      RLAST from the shared slave side
//  grnt       out  4      one-hot read grant, registered; 0 = nobody
//  grnt_idx   out  2      binary index of current/last grant, registered
//  busy       out  1      1 while a burst is owned (state ADDR or DATA)
//  timeout    out  1      one-cycle pulse when the watchdog releases a burst
// BEHAVIOUR
//  Reset: state=IDLE, grnt=0, grnt_idx=0, busy=0, timeout=0, cnt=0, last=3 (master 0 wins first).
//  Pick (combinational): first i with m_arvalid[i] set, scanning last+1, last+2, ... modulo 4.
//  States:
//  IDLE: if |m_arvalid -> ADDR; grnt<=onehot(pick), grnt_idx<=pick. Grant appears 1 cycle after request.
//  ADDR: AR handshake = m_arvalid[g] & s_arready -> DATA.
//        If m_arvalid[g] drops before handshake (protocol error): -> IDLE, grnt<=0, last unchanged.
//  DATA: end of burst = s_rvalid & m_rready[g] & s_rlast.
//        At end of burst: last<=g.
//        Other m_arvalid bits set (owner's bit masked) -> ADDR with new pick computed against last=g.
//        This gives zero-bubble handover. Otherwise -> IDLE, grnt<=0.
//        Non-last beats do not change state.
//  Watchdog: cnt clears on entry to ADDR and increments each cycle in ADDR/DATA.
//        When TO_CYC!=0 and cnt==TO_CYC-1 without leaving the state: -> IDLE, grnt<=0, last<=g, timeout=1 for one cycle.
//  Simultaneous events:
//        End of burst on the same cycle as the watchdog fires: end of burst wins, timeout stays 0.
//        AR handshake and R beats are never in the same cycle for the same burst (DATA entered after AR).
//  Priority: after master g finishes, g has the lowest priority. No master waits more than 3 bursts.
//  busy = (state!=IDLE), registered. grnt is one-hot or zero at all times.
//  Reset mid-burst: all outputs return to reset values immediately (async). last returns to 3.
// STRUCTURE
//  Shared package axi_arb_pkg: state encodings IDLE=2'd0, ADDR=2'd1, DATA=2'd2; NUM_M; onehot/index helper functions.
//  Sub-module rr_pick: combinational round-robin picker (req[3:0], last[1:0] -> valid, idx[1:0]).
//  Also reused by the write arbiter.
//  Top: state reg, grant regs, last reg, watchdog counter.
// TESTING
//  1. Reset release, m_arvalid=4'b0001 at cycle 0 -> grnt=4'b0001 at cycle 1, busy=1, grnt_idx=0.
//  2. m_arvalid=4'b1111 held, each burst 2 beats with RLAST on beat 2 -> grants 0,1,2,3,0 in order.
//     No IDLE cycle between bursts.
//  3. Master 2 bursts while master 1 asserts m_arvalid from cycle 0 -> grnt stays 4'b0100 until RLAST handshake.
//     Next cycle grnt=4'b0010.
//  4. s_rvalid=1, s_rlast=1 but m_rready[g]=0 for 3 cycles -> no release; releases the cycle after m_rready[g]=1.
//  5. TO_CYC=16, grant taken, s_arready never asserted -> timeout pulses 1 cycle at cnt=15.
//     grnt=0 next cycle. Next pick skips the stalled master.
//  6. ARESETn low mid-DATA -> grnt=0, busy=0 asynchronously; after release m_arvalid=4'b1000 -> grnt=4'b1000.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared definitions for the AXI read/write channel arbiters.
// Holds the master count, the index width, the arbiter state encoding and
// the conversions between one-hot grant vectors and binary indices.
package axi_arb_pkg;

    localparam int unsigned NUM_M = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    // Binary index to one-hot grant vector.
    function automatic logic [NUM_M-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot = NUM_M'(1) << idx;
    endfunction

    // One-hot grant vector to binary index (highest set bit wins if not one-hot).
    function automatic logic [IDX_W-1:0] to_idx(input logic [NUM_M-1:0] oh);
        to_idx = '0;
        for (int i = 0; i < int'(NUM_M); i++) begin
            if (oh[i]) begin
                to_idx = IDX_W'(i);
            end
        end
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Scans last+1, last+2, ... (modulo NUM_M) and returns the first requester,
// so the previous winner always ends up with the lowest priority.
// Ports:
//   req   - request vector, bit i = master i
//   last  - index of the most recent winner
//   valid - at least one request present
//   idx   - index of the chosen requester (0 when valid is low)
module rr_pick
    import axi_arb_pkg::*;
(
    input  logic [NUM_M-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // First hit wins; the offset NUM_M wraps back onto last itself.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 1; k <= int'(NUM_M); k++) begin
            cand = last + IDX_W'(k);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter for the shared AXI read channel (AR/R) among NUM_M masters.
// A grant is held from the AR handshake through the R beat carrying RLAST, then
// handed straight to the next requester without an idle cycle. A watchdog
// releases a burst that stays in ADDR/DATA for TO_CYC cycles.
// Ports:
//   ACLK, ARESETn - clock (rising edge) and asynchronous active-low reset
//   m_arvalid     - ARVALID per master
//   m_rready      - RREADY per master
//   s_arready     - ARREADY from the shared slave
//   s_rvalid      - RVALID from the shared slave
//   s_rlast       - RLAST from the shared slave
//   grnt          - one-hot grant (0 = nobody), registered
//   grnt_idx      - binary index of the current/last grant, registered
//   busy          - a burst is owned, registered
//   timeout       - one-cycle pulse when the watchdog releases a burst
// TO_CYC = 0 disables the watchdog; TO_W must satisfy 2**TO_W > TO_CYC.
module axi_rd_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned TO_CYC = 1024,
    parameter int unsigned TO_W   = 11
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic [NUM_M-1:0] m_arvalid,
    input  logic [NUM_M-1:0] m_rready,
    input  logic             s_arready,
    input  logic             s_rvalid,
    input  logic             s_rlast,
    output logic [NUM_M-1:0] grnt,
    output logic [IDX_W-1:0] grnt_idx,
    output logic             busy,
    output logic             timeout
);

    localparam logic [TO_W-1:0]  CNT_MAX  = TO_W'(TO_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_M - 1);

    arb_state_e       state_q, state_nxt;
    logic [NUM_M-1:0] grnt_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [IDX_W-1:0] last_q, last_nxt;
    logic [TO_W-1:0]  cnt_q, cnt_nxt;
    logic             tmo_nxt;

    logic             idle_valid, hand_valid;
    logic [IDX_W-1:0] idle_idx, hand_idx;
    logic             owner_arvalid, burst_end, wd_fire;

    // Fresh pick from IDLE against the last finished owner.
    rr_pick u_pick_idle (
        .req   (m_arvalid),
        .last  (last_q),
        .valid (idle_valid),
        .idx   (idle_idx)
    );

    // Handover pick at end of burst: owner masked, owner becomes lowest priority.
    rr_pick u_pick_hand (
        .req   (m_arvalid & ~grnt),
        .last  (grnt_idx),
        .valid (hand_valid),
        .idx   (hand_idx)
    );

    assign owner_arvalid = m_arvalid[grnt_idx];
    assign burst_end     = s_rvalid & m_rready[grnt_idx] & s_rlast;
    assign wd_fire       = (TO_CYC != 0) && (cnt_q == CNT_MAX);

    // State register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state, grant, priority pointer and watchdog.
    always_comb begin
        state_nxt = state_q;
        grnt_nxt  = grnt;
        idx_nxt   = grnt_idx;
        last_nxt  = last_q;
        cnt_nxt   = cnt_q;
        tmo_nxt   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (idle_valid) begin
                    state_nxt = ADDR;
                    grnt_nxt  = onehot(idle_idx);
                    idx_nxt   = idle_idx;
                    cnt_nxt   = '0;
                end
            end

            ADDR: begin
                cnt_nxt = cnt_q + TO_W'(1);
                if (!owner_arvalid) begin
                    // Request withdrawn before handshake: drop it, keep priority.
                    state_nxt = IDLE;
                    grnt_nxt  = '0;
                end else if (s_arready) begin
                    state_nxt = DATA;
                end else if (wd_fire) begin
                    state_nxt = IDLE;
                    grnt_nxt  = '0;
                    last_nxt  = grnt_idx;
                    tmo_nxt   = 1'b1;
                end
            end

            DATA: begin
                cnt_nxt = cnt_q + TO_W'(1);
                if (burst_end) begin
                    last_nxt = grnt_idx;
                    if (hand_valid) begin
                        state_nxt = ADDR;
                        grnt_nxt  = onehot(hand_idx);
                        idx_nxt   = hand_idx;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = IDLE;
                        grnt_nxt  = '0;
                    end
                end else if (wd_fire) begin
                    state_nxt = IDLE;
                    grnt_nxt  = '0;
                    last_nxt  = grnt_idx;
                    tmo_nxt   = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
                grnt_nxt  = '0;
            end
        endcase
    end

    // Registered outputs and datapath state.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            grnt     <= '0;
            grnt_idx <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            cnt_q    <= '0;
            last_q   <= LAST_RST;
        end else begin
            grnt     <= grnt_nxt;
            grnt_idx <= idx_nxt;
            busy     <= (state_nxt != IDLE);
            timeout  <= tmo_nxt;
            cnt_q    <= cnt_nxt;
            last_q   <= last_nxt;
        end
    end

endmodule
